regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, range 1..15; consecutive lost conflicts before port B is forced.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports reqAValid in 1, reqAAddress in ADDR_WIDTH, reqAData in DATA_WIDTH  pipeline writeback request (high priority).
REQ-007 SHALL have port reqAReady  out  1  port A request accepted this cycle when high with reqAValid.
REQ-008 SHALL have ports reqBValid in 1, reqBAddress in ADDR_WIDTH, reqBData in DATA_WIDTH  long-latency unit writeback request.
REQ-009 SHALL have port reqBReady  out  1  port B request accepted this cycle when high with reqBValid.
REQ-010 SHALL have ports writeEnable out 1, writeAddress out ADDR_WIDTH, writeData out DATA_WIDTH  registered drive of the regfile bank write port.
REQ-011 SHALL have ports readAddressA in ADDR_WIDTH, readAddressB in ADDR_WIDTH  decode-stage read addresses.
REQ-012 SHALL have ports hazardA out 1, hazardB out 1  combinational: read address targets a write not yet visible on bank read data.

Function
REQ-013 SHALL accept a request when valid and ready are both high in the same cycle; requesters hold valid/address/data stable until accepted.
REQ-014 SHALL grant at most one request per cycle.
REQ-015 SHALL grant A when only A valid, B when only B valid, neither when both low.
REQ-016 SHALL, with both valid and state PRIO_A, grant A and increment starveCount (saturating at STARVE_LIMIT).
REQ-017 SHALL transition PRIO_A -> FORCE_B on the edge where starveCount reaches STARVE_LIMIT.
REQ-018 SHALL, in FORCE_B with reqBValid high, grant B, deassert reqAReady, clear starveCount, and return to PRIO_A next cycle.
REQ-019 SHALL, in FORCE_B with reqBValid low, grant A if valid, clear starveCount, and return to PRIO_A.
REQ-020 SHALL clear starveCount on every B grant in any state.
REQ-021 SHALL drive writeEnable/writeAddress/writeData exactly one cycle after acceptance (latency 1); writeEnable high for one cycle per accepted request.
REQ-022 SHALL hold writeAddress/writeData at last values when writeEnable is low.
REQ-023 SHALL keep a second stage (stage2Valid, stage2Address) loaded from writeEnable/writeAddress each cycle, covering the bank's two-cycle write-to-read latency.
REQ-024 SHALL assert hazardX when readAddressX equals writeAddress with writeEnable high, or equals stage2Address with stage2Valid high.
REQ-025 SHALL, with back-to-back writes to the same address, raise hazard for every cycle either stage matches.

Reset
REQ-026 SHALL, while reset is high, force writeEnable 0, writeAddress 0, writeData 0, stage2Valid 0, stage2Address 0, starveCount 0, state PRIO_A.
REQ-027 SHALL hold reqAReady and reqBReady low while reset is high; no request accepted.
REQ-028 SHALL discard an accepted request whose write would issue during a reset cycle; no writeEnable after reset releases.
REQ-029 SHALL drive hazardA/hazardB 0 during reset and the first cycle after it.

Configuration
REQ-030 SHALL support macro REGFILE_ZERO_REG_EN.
REQ-031 SHALL, with REGFILE_ZERO_REG_EN defined, accept requests to address 0 normally but suppress writeEnable for them, and never assert hazard for read address 0.
REQ-032 SHALL, without REGFILE_ZERO_REG_EN, treat address 0 as an ordinary register (writes issued, hazards reported).

Verification
REQ-033 SHALL cover: A only, addr 3 data 0x11223344 cycle N -> writeEnable=1, writeAddress=3, writeData=0x11223344 at N+1; reqBReady=0 not required.
REQ-034 SHALL cover: A and B valid continuously, STARVE_LIMIT=4 -> four A grants, fifth grant B, then A resumes; repeats every 5 cycles.
REQ-035 SHALL cover: write addr 7 accepted cycle N, readAddressA=7 held -> hazardA=1 at N+1 and N+2, 0 at N+3.
REQ-036 SHALL cover: REGFILE_ZERO_REG_EN defined, B writes addr 0 -> reqBReady=1, writeEnable stays 0, hazardB=0 for readAddressB=0.
REQ-037 SHALL cover: reset asserted the cycle after an acceptance -> writeEnable=0, all outputs 0, starveCount 0; first post-reset conflict grants A.
REQ-038 SHALL cover: FORCE_B reached, reqBValid dropped same cycle, A valid -> A granted, state PRIO_A, starveCount 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request, regfile write port and hazard signal bundle
//   slave  : arbiter side (takes requests and read addresses, drives readys, write port, hazards)
//   master : requester/decode side (drives requests and read addresses)
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  reqAValid;
  logic [ADDR_WIDTH-1:0] reqAAddress;
  logic [DATA_WIDTH-1:0] reqAData;
  logic                  reqAReady;

  logic                  reqBValid;
  logic [ADDR_WIDTH-1:0] reqBAddress;
  logic [DATA_WIDTH-1:0] reqBData;
  logic                  reqBReady;

  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;

  logic [ADDR_WIDTH-1:0] readAddressA;
  logic [ADDR_WIDTH-1:0] readAddressB;
  logic                  hazardA;
  logic                  hazardB;

  modport slave (
    input  reqAValid, reqAAddress, reqAData,
    input  reqBValid, reqBAddress, reqBData,
    input  readAddressA, readAddressB,
    output reqAReady, reqBReady,
    output writeEnable, writeAddress, writeData,
    output hazardA, hazardB
  );

  modport master (
    output reqAValid, reqAAddress, reqAData,
    output reqBValid, reqBAddress, reqBData,
    output readAddressA, readAddressB,
    input  reqAReady, reqBReady,
    input  writeEnable, writeAddress, writeData,
    input  hazardA, hazardB
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-port regfile write arbiter with starvation guard and hazard detect
//   clk, reset : sole clock, synchronous active-high reset
//   bus.reqA*  : pipeline writeback request (high priority), valid/ready handshake
//   bus.reqB*  : long-latency unit writeback request, forced through after STARVE_LIMIT lost conflicts
//   bus.write* : registered regfile write port, one cycle after acceptance
//   bus.readAddressA/B, bus.hazardA/B : decode read addresses and combinational in-flight write hazards
//   Optional feature macro: REGFILE_ZERO_REG_EN (address 0 is a hardwired zero register)
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {PRIO_A, FORCE_B} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state, state_next;
  logic [3:0]            starve_count, starve_next;
  logic                  ready_a, ready_b;
  logic                  grant_a, grant_b;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_writable;
  logic                  issue;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  stage2_valid;
  logic [ADDR_WIDTH-1:0] stage2_address;
  logic                  rd_a_tracked, rd_b_tracked;

  always_comb begin
    ready_a     = 1'b0;
    ready_b     = 1'b0;
    state_next  = state;
    starve_next = starve_count;
    if (!reset) begin
      case (state)
        PRIO_A: begin
          ready_a = 1'b1;
          ready_b = !bus.reqAValid;
          if (bus.reqAValid && bus.reqBValid) begin
            // B lost a conflict; once the count reaches the limit B is forced next cycle.
            if (starve_count < LIMIT) begin
              starve_next = starve_count + 4'd1;
            end
            if (starve_count + 4'd1 >= LIMIT) begin
              state_next = FORCE_B;
            end
          end else if (bus.reqBValid) begin
            starve_next = 4'd0;
          end
        end
        FORCE_B: begin
          // B takes the slot if it is still asking; otherwise A is served.
          ready_b     = bus.reqBValid;
          ready_a     = !bus.reqBValid;
          starve_next = 4'd0;
          state_next  = PRIO_A;
        end
        default: begin
          state_next  = PRIO_A;
          starve_next = 4'd0;
        end
      endcase
    end
  end

  assign grant_a  = bus.reqAValid && ready_a;
  assign grant_b  = bus.reqBValid && ready_b;
  assign sel_addr = grant_b ? bus.reqBAddress : bus.reqAAddress;
  assign sel_data = grant_b ? bus.reqBData    : bus.reqAData;

`ifdef REGFILE_ZERO_REG_EN
  // Writes to the zero register are accepted but never reach the bank.
  assign sel_writable = (sel_addr != '0);
  assign rd_a_tracked = (bus.readAddressA != '0);
  assign rd_b_tracked = (bus.readAddressB != '0);
`else
  assign sel_writable = 1'b1;
  assign rd_a_tracked = 1'b1;
  assign rd_b_tracked = 1'b1;
`endif

  assign issue = (grant_a || grant_b) && sel_writable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PRIO_A;
      starve_count   <= 4'd0;
      we_q           <= 1'b0;
      wa_q           <= '0;
      wd_q           <= '0;
      stage2_valid   <= 1'b0;
      stage2_address <= '0;
    end else begin
      state          <= state_next;
      starve_count   <= starve_next;
      we_q           <= issue;
      if (issue) begin
        wa_q <= sel_addr;
        wd_q <= sel_data;
      end
      stage2_valid   <= we_q;
      stage2_address <= wa_q;
    end
  end

  assign bus.reqAReady = ready_a;
  assign bus.reqBReady = ready_b;

  // Masking with reset drops a write accepted just before reset asserts.
  assign bus.writeEnable  = we_q && !reset;
  assign bus.writeAddress = reset ? '0 : wa_q;
  assign bus.writeData    = reset ? '0 : wd_q;

  // A write is invisible on bank read data for two cycles: the write-port cycle and stage 2.
  assign bus.hazardA = !reset && rd_a_tracked &&
                       ((we_q && bus.readAddressA == wa_q) ||
                        (stage2_valid && bus.readAddressA == stage2_address));
  assign bus.hazardB = !reset && rd_b_tracked &&
                       ((we_q && bus.readAddressB == wa_q) ||
                        (stage2_valid && bus.readAddressB == stage2_address));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count of conflicts B has lost since its last service,
  // plus the list of the last two issued writes (still invisible on the bank).
  int          lost;
  bit          h1v, h2v;
  logic [AW-1:0] h1a, h2a, m_wa;
  logic [DW-1:0] m_wd;

  function automatic bit zero_masked(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_hazard(input logic [AW-1:0] ra);
    if (zero_masked(ra)) return 1'b0;
    return (h1v && ra == h1a) || (h2v && ra == h2a);
  endfunction

  task automatic model_reset();
    lost = 0; h1v = 0; h2v = 0; h1a = '0; h2a = '0; m_wa = '0; m_wd = '0;
  endtask

  function automatic void model_grant(input bit a, input bit b, output bit ga, output bit gb);
    ga = 0; gb = 0;
    if (lost >= SL) begin
      if (b) gb = 1; else if (a) ga = 1;
    end else if (a) ga = 1;
    else if (b) gb = 1;
  endfunction

  // Commit the model for the current cycle and move to the next falling edge.
  task automatic tick(output bit ga, output bit gb);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit iss;
    model_grant(bus.reqAValid, bus.reqBValid, ga, gb);
    a = gb ? bus.reqBAddress : bus.reqAAddress;
    d = gb ? bus.reqBData : bus.reqAData;
    if (lost >= SL || gb) lost = 0;
    else if (ga && bus.reqBValid) lost = lost + 1;
    iss = (ga || gb) && !zero_masked(a);
    h2v = h1v; h2a = h1a;
    h1v = iss; h1a = a;
    if (iss) begin m_wa = a; m_wd = d; end
    @(negedge clk);
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus.reqAValid = av; bus.reqAAddress = aa; bus.reqAData = ad;
    bus.reqBValid = bv; bus.reqBAddress = ba; bus.reqBData = bd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
    bus.readAddressA = '0; bus.readAddressB = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.reqAReady !== 1'b0) begin errors++; $display("FAIL rst_readyA got %0b want 0", bus.reqAReady); end
    checks++; if (bus.reqBReady !== 1'b0) begin errors++; $display("FAIL rst_readyB got %0b want 0", bus.reqBReady); end
    checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", bus.writeEnable); end
    checks++; if (bus.writeAddress !== '0 || bus.writeData !== '0) begin errors++; $display("FAIL rst_wr got %0h/%0h want 0/0", bus.writeAddress, bus.writeData); end
    checks++; if (bus.hazardA !== 1'b0 || bus.hazardB !== 1'b0) begin errors++; $display("FAIL rst_hazard got %0b%0b want 00", bus.hazardA, bus.hazardB); end
    do_reset();
  endtask

  task automatic test_a_only();
    bit ga, gb;
    do_reset();
    drive(1, 5'd3, 32'h11223344, 0, '0, '0);
    #1;
    checks++; if (bus.reqAReady !== 1'b1) begin errors++; $display("FAIL aonly_ready got %0b want 1", bus.reqAReady); end
    tick(ga, gb);
    drive(0, '0, '0, 0, '0, '0);
    #1;
    checks++; if (bus.writeEnable !== 1'b1 || bus.writeAddress !== 5'd3 || bus.writeData !== 32'h11223344)
      begin errors++; $display("FAIL aonly_write got %0b/%0d/%0h want 1/3/11223344", bus.writeEnable, bus.writeAddress, bus.writeData); end
    tick(ga, gb);
    #1;
    checks++; if (bus.writeEnable !== 1'b0 || bus.writeAddress !== 5'd3 || bus.writeData !== 32'h11223344)
      begin errors++; $display("FAIL aonly_hold got %0b/%0d/%0h want 0/3/11223344", bus.writeEnable, bus.writeAddress, bus.writeData); end
    drive(0, '0, '0, 1, 5'd12, 32'hBBBB0001);
    #1;
    checks++; if (bus.reqBReady !== 1'b1) begin errors++; $display("FAIL bonly_ready got %0b want 1", bus.reqBReady); end
    tick(ga, gb);
    drive(0, '0, '0, 0, '0, '0);
    #1;
    checks++; if (bus.writeEnable !== 1'b1 || bus.writeAddress !== 5'd12 || bus.writeData !== 32'hBBBB0001)
      begin errors++; $display("FAIL bonly_write got %0b/%0d/%0h want 1/12/bbbb0001", bus.writeEnable, bus.writeAddress, bus.writeData); end
  endtask

  // Continuous conflict: every fifth grant goes to B.
  task automatic conflict_run(input int n, input string tag);
    bit ga, gb;
    for (int k = 0; k < n; k++) begin
      drive(1, AW'(k + 1), 32'(32'hA0000000 + k), 1, AW'(k + 20), 32'(32'hB0000000 + k));
      #1;
      checks++; if ((bus.reqAValid && bus.reqAReady) !== (k % 5 != 4))
        begin errors++; $display("FAIL %s_grantA[%0d] got %0b want %0b", tag, k, bus.reqAReady, (k % 5 != 4)); end
      checks++; if ((bus.reqBValid && bus.reqBReady) !== (k % 5 == 4))
        begin errors++; $display("FAIL %s_grantB[%0d] got %0b want %0b", tag, k, bus.reqBReady, (k % 5 == 4)); end
      tick(ga, gb);
      #1;
      checks++; if (bus.writeData !== ((k % 5 == 4) ? 32'(32'hB0000000 + k) : 32'(32'hA0000000 + k)))
        begin errors++; $display("FAIL %s_data[%0d] got %0h", tag, k, bus.writeData); end
    end
    drive(0, '0, '0, 0, '0, '0);
  endtask

  task automatic test_starvation();
    do_reset();
    conflict_run(15, "starve");
  endtask

  task automatic test_force_b_drop();
    bit ga, gb;
    do_reset();
    for (int k = 0; k < SL; k++) begin
      drive(1, 5'd1, 32'(k), 1, 5'd2, 32'hF0);
      #1;
      tick(ga, gb);
    end
    drive(1, 5'd5, 32'h55, 0, 5'd2, 32'hF0);
    #1;
    checks++; if (bus.reqAReady !== 1'b1) begin errors++; $display("FAIL forceb_drop_readyA got %0b want 1", bus.reqAReady); end
    tick(ga, gb);
    #1;
    checks++; if (bus.writeEnable !== 1'b1 || bus.writeAddress !== 5'd5)
      begin errors++; $display("FAIL forceb_drop_write got %0b/%0d want 1/5", bus.writeEnable, bus.writeAddress); end
    conflict_run(5, "after_drop");
  endtask

  task automatic test_hazard();
    bit ga, gb;
    do_reset();
    bus.readAddressA = 5'd7; bus.readAddressB = 5'd9;
    drive(1, 5'd7, 32'h7777, 0, '0, '0);
    #1;
    checks++; if (bus.hazardA !== 1'b0) begin errors++; $display("FAIL haz_n got %0b want 0", bus.hazardA); end
    tick(ga, gb);
    drive(0, '0, '0, 0, '0, '0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (bus.hazardA !== (k < 3)) begin errors++; $display("FAIL haz_n+%0d got %0b want %0b", k, bus.hazardA, (k < 3)); end
      tick(ga, gb);
    end
    drive(1, 5'd9, 32'h9001, 0, '0, '0);
    #1;
    tick(ga, gb);
    drive(1, 5'd9, 32'h9002, 0, '0, '0);
    #1;
    tick(ga, gb);
    drive(0, '0, '0, 0, '0, '0);
    for (int k = 2; k <= 4; k++) begin
      #1;
      checks++; if (bus.hazardB !== (k < 4)) begin errors++; $display("FAIL b2b_haz_n+%0d got %0b want %0b", k, bus.hazardB, (k < 4)); end
      tick(ga, gb);
    end
  endtask

  task automatic test_reset_after_accept();
    bit ga, gb;
    do_reset();
    for (int k = 0; k < SL - 1; k++) begin
      drive(1, 5'd1, 32'(k), 1, 5'd2, 32'hF0);
      #1;
      tick(ga, gb);
    end
    drive(1, 5'd3, 32'h33, 1, 5'd2, 32'hF0);
    #1;
    tick(ga, gb);
    reset = 1'b1;
    bus.readAddressA = 5'd3;
    drive(1, 5'd4, 32'h44, 1, 5'd2, 32'hF0);
    #1;
    checks++; if (bus.writeEnable !== 1'b0 || bus.writeAddress !== '0 || bus.writeData !== '0)
      begin errors++; $display("FAIL rstacc_wr got %0b/%0d/%0h want 0/0/0", bus.writeEnable, bus.writeAddress, bus.writeData); end
    checks++; if (bus.hazardA !== 1'b0 || bus.reqAReady !== 1'b0 || bus.reqBReady !== 1'b0)
      begin errors++; $display("FAIL rstacc_haz_ready got %0b%0b%0b want 000", bus.hazardA, bus.reqAReady, bus.reqBReady); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(0, '0, '0, 0, '0, '0);
    #1;
    checks++; if (bus.writeEnable !== 1'b0 || bus.hazardA !== 1'b0)
      begin errors++; $display("FAIL rstacc_post got we=%0b haz=%0b want 0/0", bus.writeEnable, bus.hazardA); end
    tick(ga, gb);
    conflict_run(5, "post_rst");
  endtask

  task automatic test_zero_reg();
    bit ga, gb;
    do_reset();
    bus.readAddressB = '0;
    drive(0, '0, '0, 1, '0, 32'hDEAD0000);
    #1;
    checks++; if (bus.reqBReady !== 1'b1) begin errors++; $display("FAIL zero_ready got %0b want 1", bus.reqBReady); end
    tick(ga, gb);
    drive(0, '0, '0, 0, '0, '0);
    #1;
`ifdef REGFILE_ZERO_REG_EN
    checks++; if (bus.writeEnable !== 1'b0 || bus.hazardB !== 1'b0)
      begin errors++; $display("FAIL zero_suppress got we=%0b haz=%0b want 0/0", bus.writeEnable, bus.hazardB); end
`else
    checks++; if (bus.writeEnable !== 1'b1 || bus.writeData !== 32'hDEAD0000 || bus.hazardB !== 1'b1)
      begin errors++; $display("FAIL zero_ordinary got we=%0b d=%0h haz=%0b want 1/dead0000/1", bus.writeEnable, bus.writeData, bus.hazardB); end
`endif
    tick(ga, gb);
  endtask

  task automatic test_random(input int n);
    bit ga = 0, gb = 0, ea, eb;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (ga) bus.reqAValid = 1'b0;
      if (gb) bus.reqBValid = 1'b0;
      if (!bus.reqAValid && $urandom_range(0, 2) != 0) begin
        bus.reqAValid = 1'b1; bus.reqAAddress = AW'($urandom_range(0, 7)); bus.reqAData = $urandom;
      end
      if (!bus.reqBValid && $urandom_range(0, 2) != 0) begin
        bus.reqBValid = 1'b1; bus.reqBAddress = AW'($urandom_range(0, 7)); bus.reqBData = $urandom;
      end
      bus.readAddressA = AW'($urandom_range(0, 7));
      bus.readAddressB = AW'($urandom_range(0, 7));
      #1;
      model_grant(bus.reqAValid, bus.reqBValid, ea, eb);
      checks++; if ((bus.reqAValid && bus.reqAReady) !== ea) begin errors++; $display("FAIL rnd_grantA[%0d] got %0b want %0b", c, bus.reqAReady, ea); end
      checks++; if ((bus.reqBValid && bus.reqBReady) !== eb) begin errors++; $display("FAIL rnd_grantB[%0d] got %0b want %0b", c, bus.reqBReady, eb); end
      checks++; if (bus.hazardA !== exp_hazard(bus.readAddressA)) begin errors++; $display("FAIL rnd_hazA[%0d] got %0b want %0b", c, bus.hazardA, exp_hazard(bus.readAddressA)); end
      checks++; if (bus.hazardB !== exp_hazard(bus.readAddressB)) begin errors++; $display("FAIL rnd_hazB[%0d] got %0b want %0b", c, bus.hazardB, exp_hazard(bus.readAddressB)); end
      tick(ga, gb);
      checks++; if (bus.writeEnable !== h1v || bus.writeAddress !== m_wa || bus.writeData !== m_wd)
        begin errors++; $display("FAIL rnd_write[%0d] got %0b/%0d/%0h want %0b/%0d/%0h", c, bus.writeEnable, bus.writeAddress, bus.writeData, h1v, m_wa, m_wd); end
    end
    drive(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    bus.readAddressA = '0; bus.readAddressB = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_a_only();
    test_starvation();
    test_force_b_drop();
    test_hazard();
    test_reset_after_accept();
    test_zero_reg();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
